// File: rtl/periph_rr_arbiter_ot_if.sv
// ---------------------------------------------------------------------------
// periph_rr_arbiter_ot_if
//
// Bundles the request/response bus of the round-robin peripheral arbiter.
// Carries both sides: the N core-side request ports (flattened per-master
// vectors) and the single peripheral-target port.
//
// Modports:
//   slave  - the arbiter's view. It receives master requests and target
//            responses. It drives grants, routed responses and the
//            target request.
//   master - the environment's view. This covers the core-side requesters
//            plus the peripheral target, and is the mirror of 'slave'.
//
// Signals (N = N_MASTER):
//   req_i/add_i/wen_i/atop_i/wdata_i/be_i   per-master request and payload
//   gnt_o/r_valid_o                         per-master grant / response valid
//   r_rdata_o                               response data, broadcast
//   slv_req_o/slv_add_o/.../slv_be_o        request + payload to the target
//   slv_gnt_i/slv_r_valid_i/slv_r_rdata_i   target grant / response
// ---------------------------------------------------------------------------
interface periph_rr_arbiter_ot_if #(
    parameter int N_MASTER   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
);
    // core-side requests
    logic [N_MASTER-1:0]            req_i;
    logic [N_MASTER*ADDR_WIDTH-1:0] add_i;
    logic [N_MASTER-1:0]            wen_i;
    logic [N_MASTER*6-1:0]          atop_i;
    logic [N_MASTER*DATA_WIDTH-1:0] wdata_i;
    logic [N_MASTER*BE_WIDTH-1:0]   be_i;

    // core-side grants and responses
    logic [N_MASTER-1:0]            gnt_o;
    logic [N_MASTER-1:0]            r_valid_o;
    logic [DATA_WIDTH-1:0]          r_rdata_o;

    // target-side request
    logic                           slv_req_o;
    logic [ADDR_WIDTH-1:0]          slv_add_o;
    logic                           slv_wen_o;
    logic [5:0]                     slv_atop_o;
    logic [DATA_WIDTH-1:0]          slv_wdata_o;
    logic [BE_WIDTH-1:0]            slv_be_o;

    // target-side grant and response
    logic                           slv_gnt_i;
    logic                           slv_r_valid_i;
    logic [DATA_WIDTH-1:0]          slv_r_rdata_i;

    modport slave (
        input  req_i, add_i, wen_i, atop_i, wdata_i, be_i,
        input  slv_gnt_i, slv_r_valid_i, slv_r_rdata_i,
        output gnt_o, r_valid_o, r_rdata_o,
        output slv_req_o, slv_add_o, slv_wen_o, slv_atop_o, slv_wdata_o, slv_be_o
    );

    modport master (
        output req_i, add_i, wen_i, atop_i, wdata_i, be_i,
        output slv_gnt_i, slv_r_valid_i, slv_r_rdata_i,
        input  gnt_o, r_valid_o, r_rdata_o,
        input  slv_req_o, slv_add_o, slv_wen_o, slv_atop_o, slv_wdata_o, slv_be_o
    );
endinterface

// File: rtl/periph_rr_arbiter_ot.sv
// ---------------------------------------------------------------------------
// periph_rr_arbiter_ot
//
// N-master to 1-slave round-robin arbiter with grant-based flow control.
// Each accepted transaction pushes the index of its master into an in-order
// FIFO. Each response from the target pops that FIFO and is routed to the
// master at its head. Responses must therefore return in grant order.
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous reset, active-high
//   bus            arbiter side (slave modport) of periph_rr_arbiter_ot_if
//   outstanding_o  number of granted-but-unanswered transactions
//   resp_err_o     sticky flag: response arrived with nothing outstanding
// ---------------------------------------------------------------------------
module periph_rr_arbiter_ot #(
    parameter int N_MASTER        = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int BE_WIDTH        = DATA_WIDTH / 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    periph_rr_arbiter_ot_if.slave                  bus,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   resp_err_o
);
    localparam int IDX_W = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [N_MASTER-1:0] ONE = N_MASTER'(1);

    // ---------------------------------------------------------------- state
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] fifo_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             resp_err;

    // ------------------------------------------------------------ decisions
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] cand;
    logic             found;
    logic             any_req;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             orphan;
    logic [IDX_W-1:0] head;
    int               idx;

    assign any_req = |bus.req_i;
    // Full is taken from the registered count, so a response popping in the
    // same cycle does not open a slot until the next cycle.
    assign full    = (count == CNT_W'(MAX_OUTSTANDING));
    assign empty   = (count == '0);
    assign head    = fifo_mem[rd_ptr];

    // Cyclic scan starting at rr_ptr; the first requester wins.
    // NOTE: every variable gets a default before the loop so that no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N_MASTER; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_MASTER) idx = idx - N_MASTER;
            cand = IDX_W'(idx);
            if (!found && bus.req_i[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign push   = bus.slv_req_o & bus.slv_gnt_i;
    assign pop    = bus.slv_r_valid_i & ~empty & ~rst;
    assign orphan = bus.slv_r_valid_i & empty;

    // ------------------------------------------------------------- outputs
    assign bus.slv_req_o = any_req & ~full & ~rst;

    always_comb begin
        bus.slv_add_o   = '0;
        bus.slv_wen_o   = 1'b0;
        bus.slv_atop_o  = '0;
        bus.slv_wdata_o = '0;
        bus.slv_be_o    = '0;
        if (any_req) begin
            bus.slv_add_o   = bus.add_i  [winner*ADDR_WIDTH +: ADDR_WIDTH];
            bus.slv_wen_o   = bus.wen_i  [winner];
            bus.slv_atop_o  = bus.atop_i [winner*6 +: 6];
            bus.slv_wdata_o = bus.wdata_i[winner*DATA_WIDTH +: DATA_WIDTH];
            bus.slv_be_o    = bus.be_i   [winner*BE_WIDTH +: BE_WIDTH];
        end
    end

    assign bus.gnt_o     = push ? (ONE << winner) : '0;
    assign bus.r_valid_o = pop  ? (ONE << head)   : '0;
    assign bus.r_rdata_o = bus.slv_r_rdata_i;

    assign outstanding_o = count;
    assign resp_err_o    = resp_err;

    // ----------------------------------------------------------- sequential
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            resp_err <= 1'b0;
        end else begin
            if (push) begin
                rr_ptr <= (winner == IDX_W'(N_MASTER - 1)) ? '0 : winner + 1'b1;
                wr_ptr <= (wr_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (orphan) resp_err <= 1'b1;
        end
    end

    // NOTE: the FIFO storage has no reset. Entries are only read below the
    // occupancy count, and that count is reset.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= winner;
    end
endmodule

// File: tb/tb_periph_rr_arbiter_ot.sv
// ---------------------------------------------------------------------------
// tb_periph_rr_arbiter_ot
//
// Bench for periph_rr_arbiter_ot (N_MASTER=4, MAX_OUTSTANDING=4).
// A reference model holds the round-robin pointer as an integer and the
// outstanding transactions as a queue of master indices. It predicts grants,
// routed responses, payload, occupancy and the sticky error flag every cycle.
// Directed scenarios come first, followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_periph_rr_arbiter_ot;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MO = 4;
    localparam int CW = $clog2(MO + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] outstanding;
    logic          resp_err;

    always #5 clk = ~clk;

    periph_rr_arbiter_ot_if #(.N_MASTER(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) bus ();

    periph_rr_arbiter_ot #(
        .N_MASTER(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .outstanding_o (outstanding),
        .resp_err_o    (resp_err)
    );

    int n_pass   = 0;
    int n_checks = 0;

    // reference model state
    int m_rr  = 0;
    int m_q[$];
    bit m_err = 1'b0;

    // last sampled outputs
    logic [N-1:0] obs_gnt;
    logic [N-1:0] obs_rv;
    logic         obs_req;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    // One clock cycle. Inputs are applied at posedge+1, outputs are compared
    // against the model at posedge+5, and the model advances after the edge.
    task automatic cycle(input logic [N-1:0] req, input bit g, input bit rv);
        logic [AW-1:0] add_v   [N];
        logic [DW-1:0] wdata_v [N];
        logic [BW-1:0] be_v    [N];
        logic [5:0]    atop_v  [N];
        logic          wen_v   [N];
        logic [DW-1:0] rdata;
        logic [N-1:0]  e_gnt;
        logic [N-1:0]  e_rv;
        bit            any;
        bit            found;
        bit            e_req;
        bit            hs;
        bit            pop;
        bit            was_empty;
        int            w;

        for (int i = 0; i < N; i++) begin
            add_v[i]   = $urandom;
            wdata_v[i] = $urandom;
            be_v[i]    = BW'($urandom);
            atop_v[i]  = 6'($urandom);
            wen_v[i]   = 1'($urandom);
            bus.add_i  [i*AW +: AW] = add_v[i];
            bus.wdata_i[i*DW +: DW] = wdata_v[i];
            bus.be_i   [i*BW +: BW] = be_v[i];
            bus.atop_i [i*6 +: 6]   = atop_v[i];
            bus.wen_i  [i]          = wen_v[i];
        end
        rdata             = $urandom;
        bus.req_i         = req;
        bus.slv_gnt_i     = g;
        bus.slv_r_valid_i = rv;
        bus.slv_r_rdata_i = rdata;

        if (rst) begin
            m_q.delete();
            m_rr  = 0;
            m_err = 1'b0;
        end

        #4;
        any   = |req;
        found = 1'b0;
        w     = 0;
        for (int k = 0; k < N; k++) begin
            int cand = (m_rr + k) % N;
            if (!found && req[cand]) begin
                found = 1'b1;
                w     = cand;
            end
        end
        e_req     = any && (m_q.size() < MO) && !rst;
        hs        = e_req && g;
        pop       = rv && (m_q.size() > 0) && !rst;
        was_empty = (m_q.size() == 0);
        e_gnt     = hs  ? N'(1) << w      : '0;
        e_rv      = pop ? N'(1) << m_q[0] : '0;

        obs_gnt = bus.gnt_o;
        obs_rv  = bus.r_valid_o;
        obs_req = bus.slv_req_o;

        check("slv_req",     obs_req,  e_req);
        check("gnt",         obs_gnt,  e_gnt);
        check("r_valid",     obs_rv,   e_rv);
        check("r_rdata",     bus.r_rdata_o, rdata);
        check("outstanding", outstanding,   m_q.size());
        check("resp_err",    resp_err,      m_err);
        check("slv_add",     bus.slv_add_o,   any ? add_v[w]   : '0);
        check("slv_wdata",   bus.slv_wdata_o, any ? wdata_v[w] : '0);
        check("slv_be",      bus.slv_be_o,    any ? be_v[w]    : '0);
        check("slv_atop",    bus.slv_atop_o,  any ? atop_v[w]  : '0);
        check("slv_wen",     bus.slv_wen_o,   any ? wen_v[w]   : 1'b0);

        @(posedge clk);
        #1;
        if (!rst) begin
            if (rv && was_empty) m_err = 1'b1;
            if (pop) void'(m_q.pop_front());
            if (hs) begin
                m_q.push_back(w);
                m_rr = (w + 1) % N;
            end
        end
    endtask

    // Cycle plus explicit hand-derived expectations for grant and response.
    task automatic step(input string tag, input logic [N-1:0] req, input bit g, input bit rv,
                        input logic [N-1:0] exp_gnt, input logic [N-1:0] exp_rv);
        cycle(req, g, rv);
        check({tag, "_gnt"}, obs_gnt, exp_gnt);
        check({tag, "_rv"},  obs_rv,  exp_rv);
    endtask

    initial begin
        rst               = 1'b1;
        bus.req_i         = '0;
        bus.add_i         = '0;
        bus.wen_i         = '0;
        bus.atop_i        = '0;
        bus.wdata_i       = '0;
        bus.be_i          = '0;
        bus.slv_gnt_i     = 1'b0;
        bus.slv_r_valid_i = 1'b0;
        bus.slv_r_rdata_i = '0;
        #1;

        // reset: everything quiet even with requests and a response present
        step("rst_hold", 4'b1111, 1'b1, 1'b1, 4'b0000, 4'b0000);
        check("rst_req", obs_req, 1'b0);
        check("rst_outstanding", outstanding, 0);
        check("rst_err", resp_err, 1'b0);
        rst = 1'b0;

        // all masters requesting: 0,1,2,3,0, responses one cycle behind
        step("rr_a", 4'b1111, 1'b1, 1'b0, 4'b0001, 4'b0000);
        step("rr_b", 4'b1111, 1'b1, 1'b1, 4'b0010, 4'b0001);
        step("rr_c", 4'b1111, 1'b1, 1'b1, 4'b0100, 4'b0010);
        step("rr_d", 4'b1111, 1'b1, 1'b1, 4'b1000, 4'b0100);
        step("rr_e", 4'b1111, 1'b1, 1'b1, 4'b0001, 4'b1000);
        step("rr_f", 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0001);
        check("rr_drained", outstanding, 0);

        // pointer wrap: grant 1 (ptr -> 2), then 0011 wraps to master 0 (ptr -> 1)
        step("wrap_a", 4'b0010, 1'b1, 1'b0, 4'b0010, 4'b0000);
        step("wrap_b", 4'b0011, 1'b1, 1'b0, 4'b0001, 4'b0000);
        step("wrap_c", 4'b0011, 1'b1, 1'b0, 4'b0010, 4'b0000);
        // no grant from the target: pointer must not move
        step("hold_a", 4'b0011, 1'b0, 1'b1, 4'b0000, 4'b0010);
        step("hold_b", 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0001);
        step("hold_c", 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0010);

        // fill to MAX_OUTSTANDING, then stall
        for (int i = 0; i < MO; i++) step("fill", 4'b0001, 1'b1, 1'b0, 4'b0001, 4'b0000);
        check("full_count", outstanding, MO);
        step("full_stall", 4'b0001, 1'b1, 1'b0, 4'b0000, 4'b0000);
        check("full_req", obs_req, 1'b0);
        // pop while full: no same-cycle grant, grant resumes next cycle
        step("full_pop", 4'b0001, 1'b1, 1'b1, 4'b0000, 4'b0001);
        check("full_pop_req", obs_req, 1'b0);
        step("full_resume", 4'b0001, 1'b1, 1'b0, 4'b0001, 4'b0000);
        for (int i = 0; i < MO; i++) step("drain", 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0001);
        check("drain_count", outstanding, 0);

        // orphan response: not routed, sticky error
        step("orphan", 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000);
        check("err_set", resp_err, 1'b1);
        step("err_keep_a", 4'b0001, 1'b1, 1'b0, 4'b0001, 4'b0000);
        step("err_keep_b", 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0001);
        check("err_sticky", resp_err, 1'b1);

        // three outstanding with pointer at 2, then reset mid-operation
        step("pre_a", 4'b1111, 1'b1, 1'b0, 4'b0010, 4'b0000);
        step("pre_b", 4'b1111, 1'b1, 1'b0, 4'b0100, 4'b0000);
        step("pre_c", 4'b0010, 1'b1, 1'b0, 4'b0010, 4'b0000);
        check("pre_count", outstanding, 3);
        rst = 1'b1;
        #1;
        check("mid_rst_count", outstanding, 0);
        check("mid_rst_err", resp_err, 1'b0);
        step("mid_rst", 4'b1111, 1'b1, 1'b0, 4'b0000, 4'b0000);
        check("mid_rst_req", obs_req, 1'b0);
        rst = 1'b0;
        // late response for a discarded transaction
        step("late_rsp", 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000);
        check("late_err", resp_err, 1'b1);
        // pointer is back at 0: lowest requester wins
        step("post_rst", 4'b1110, 1'b1, 1'b0, 4'b0010, 4'b0000);

        // randomized traffic against the model
        rst = 1'b1;
        cycle(4'b0000, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] req;
            bit g;
            bit rv;
            req = N'($urandom);
            g   = ($urandom_range(3) != 0);
            rv  = (m_q.size() > 0) && ($urandom_range(1) == 1);
            cycle(req, g, rv);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
